apb_i2c_req_arbiter: RTL and testbench
======================================

// Module: apb_i2c_req_arbiter
// PURPOSE
//  Shares the single APB slave port of the APB-to-I2C EEPROM bridge among N_REQ
//  command requesters (e.g. CPU shim, boot loader, test DMA).
//  - Arbitrates round-robin and latches one command.
//  - Drives a compliant APB SETUP/ACCESS sequence to the bridge.
//  - Waits on apb_ready and routes rdata/slverr back to the granted requester.
//  - Sits between the requesters and the bridge in the dut wrapper.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  ADDR_W       32   APB address width
//  DATA_W       32   APB data width
//  TIMEOUT_CYC  1024 ACCESS-phase cycles before abort (APB_ARB_TIMEOUT_EN only)
// PORTS
//  clk          in   1             single clock, shared with the bridge
//  rst_n        in   1             asynchronous reset, active low
//  req_valid    in   N_REQ         per-requester command valid
//  req_ready    out  N_REQ         one-hot accept pulse; command is latched this cycle
//  req_write    in   N_REQ         1 = write, 0 = read
//  req_addr     in   N_REQ*ADDR_W  packed addresses; requester i = [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_REQ*DATA_W  packed write data
//  rsp_valid    out  N_REQ         one-hot, 1-cycle completion pulse
//  rsp_rdata    out  DATA_W        read data; valid only with rsp_valid
//  rsp_err      out  1             slverr/timeout flag; valid only with rsp_valid
//  apb_addr     out  ADDR_W        to bridge
//  apb_wdata    out  DATA_W        to bridge
//  apb_write    out  1             to bridge
//  apb_sel      out  1             to bridge
//  apb_enable   out  1             to bridge
//  apb_rdata    in   DATA_W        from bridge
//  apb_ready    in   1             from bridge
//  apb_slverr   in   1             from bridge
// BEHAVIOUR
//  Reset: all outputs are 0, FSM is IDLE, rr_ptr is 0; async assert, sync deassert.
//  FSM:
//  - IDLE: if any req_valid, grant the first valid index at or after rr_ptr (wrapping).
//    Pulse req_ready[g] and latch addr/wdata/write/g. Go to SETUP.
//  - SETUP: apb_sel=1, apb_enable=0, addr/wdata/write driven from the latch. 1 cycle. Go to ACCESS.
//  - ACCESS: apb_sel=1, apb_enable=1, held until apb_ready=1.
//    Same cycle: capture apb_rdata (forced to 0 for writes) and apb_slverr. Go to RESP.
//  - RESP: apb_sel=apb_enable=0. rsp_valid[g]=1, rsp_rdata and rsp_err driven.
//    rr_ptr <= (g+1) mod N_REQ. Go to IDLE.
//  Latency: accept at T; SETUP T+1; ACCESS T+2; ready at T+2+k gives rsp_valid at T+3+k.
//  Minimum 4 cycles per transfer.
//  Outputs: apb_addr/wdata/write remain stable from SETUP through the end of ACCESS.
//  They are 0 in IDLE.
//  Boundaries:
//  - req_valid dropped before accept: no transfer.
//  - Inputs after accept are ignored; only the latched command is used.
//  - Simultaneous requests: strict round-robin. Each of N continuously-valid requesters
//    is served once per N transfers.
//  - rr_ptr wraps N_REQ-1 to 0. A non-granted valid requester waits at most N_REQ-1 transfers.
//  - apb_ready in SETUP or IDLE is ignored.
//  - Reset mid-ACCESS: sel/enable drop immediately and no rsp_valid is issued.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined:
//  - 16-bit counter clears on entering ACCESS.
//  - Reaching TIMEOUT_CYC-1 without apb_ready aborts: RESP with rsp_err=1, rsp_rdata=0.
//  - sel/enable deassert on entering RESP.
//  APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.
// STRUCTURE
//  Package apb_i2c_arb_pkg: arb_state_e {IDLE,SETUP,ACCESS,RESP}, default widths,
//  and an apb_cmd_t struct {write, addr, wdata}.
//  Sub-module rr_arbiter #(N_REQ): inputs req, ptr; outputs grant one-hot, grant_idx, any.
//  Purely combinational.
// TESTING
//  1 Single read: req_valid[0], addr=0x04 -> req_ready[0] at T. sel at T+1; enable at T+2.
//    With ready at T+2 and apb_rdata=0xA5 -> rsp_valid[0] at T+3, rsp_rdata=0xA5, rsp_err=0.
//  2 Write with wait: req_write[2]=1, addr=0x08, wdata=0x5A, ready held low 5 cycles
//    -> addr/wdata stable across all ACCESS cycles; rsp_valid[2] at T+8; rsp_rdata=0.
//  3 Contention: all 4 req_valid held high for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
//  4 Slave error: apb_slverr=1 with ready on req 1 -> rsp_valid[1]=1, rsp_err=1.
//  5 Reset mid-ACCESS: rst_n low at T+3 -> all outputs 0 that cycle; next grant index 0.
//  6 (APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16) ready never asserted -> rsp_err=1 with
//    rsp_rdata=0 after 16 ACCESS cycles; apb_sel low afterwards.

Source files
------------

// File: rtl/apb_i2c_arb_pkg.sv
// Shared types and default widths for the APB requester arbiter.
// Contents: arb_state_e FSM encoding, default parameter values, apb_cmd_t payload.
// Optional feature macro used by the arbiter: APB_ARB_TIMEOUT_EN.
package apb_i2c_arb_pkg;

  localparam int unsigned N_REQ_DEF       = 4;
  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // One latched APB command at default widths.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
// Ports:
//   req       in  N_REQ          request vector
//   ptr       in  clog2(N_REQ)   highest-priority index
//   grant     out N_REQ          one-hot grant (zero when no request)
//   grant_idx out clog2(N_REQ)   index of the granted request
//   any       out 1              at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] idx;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_i2c_req_arbiter.sv
// Shares one APB master port to the I2C EEPROM bridge among N_REQ requesters.
// Round-robin accept, latched command, APB SETUP/ACCESS, one-hot response pulse.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC
// cycles without apb_ready (response flagged with rsp_err=1, rsp_rdata=0).
// Ports:
//   clk, rst_n                clock, async active-low reset
//   req_valid/write/addr/wdata per-requester command (addr/wdata packed)
//   req_ready                 one-hot accept (decoded from state, same cycle as latch)
//   rsp_valid/rsp_rdata/rsp_err registered completion pulse and data
//   apb_addr/wdata/write/sel/enable  registered APB request to bridge
//   apb_rdata/ready/slverr    APB response from bridge
module apb_i2c_req_arbiter
  import apb_i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   apb_addr,
  output logic [DATA_W-1:0]   apb_wdata,
  output logic                apb_write,
  output logic                apb_sel,
  output logic                apb_enable,
  input  logic [DATA_W-1:0]   apb_rdata,
  input  logic                apb_ready,
  input  logic                apb_slverr
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_err
    $error("apb_i2c_req_arbiter: unsupported parameter values");
  end

  arb_state_e          state_q, state_d;
  logic                run_q;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                sel_q, sel_d;
  logic                en_q, en_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = 16;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Accept is only offered in IDLE; run_q keeps it low through and just after reset.
  assign req_ready = (state_q == IDLE && run_q) ? arb_grant : '0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    sel_d       = sel_q;
    en_d        = en_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (run_q && arb_any) begin
          state_d = SETUP;
          gidx_d  = arb_idx;
          addr_d  = req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[32'(arb_idx)*DATA_W +: DATA_W];
          write_d = req_write[arb_idx];
          sel_d   = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        en_d    = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ACCESS: begin
        if (apb_ready) begin
          state_d     = RESP;
          sel_d       = 1'b0;
          en_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          write_d     = 1'b0;
          rsp_valid_d = N_REQ'(1) << gidx_q;
          rsp_rdata_d = write_q ? '0 : apb_rdata;
          rsp_err_d   = apb_slverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d     = RESP;
          sel_d       = 1'b0;
          en_d        = 1'b0;
          addr_d      = '0;
          wdata_d     = '0;
          write_d     = 1'b0;
          rsp_valid_d = N_REQ'(1) << gidx_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      RESP: begin
        state_d  = IDLE;
        rr_ptr_d = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      sel_q       <= 1'b0;
      en_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign apb_addr   = addr_q;
  assign apb_wdata  = wdata_q;
  assign apb_write  = write_q;
  assign apb_sel    = sel_q;
  assign apb_enable = en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_apb_i2c_req_arbiter.sv
// Directed bench for apb_i2c_req_arbiter (N_REQ=4, 32-bit APB).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_apb_i2c_req_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  apb_addr;
  logic [31:0]  apb_wdata;
  logic         apb_write;
  logic         apb_sel;
  logic         apb_enable;
  logic [31:0]  apb_rdata;
  logic         apb_ready;
  logic         apb_slverr;

  int vec_cnt;
  int err_cnt;

  apb_i2c_req_arbiter #(
    .N_REQ       (4),
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_addr   (apb_addr),
    .apb_wdata  (apb_wdata),
    .apb_write  (apb_write),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_rdata  (apb_rdata),
    .apb_ready  (apb_ready),
    .apb_slverr (apb_slverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111; req_write = '0; req_addr = '0; req_wdata = '0;
    apb_rdata = '0; apb_ready = 1'b0; apb_slverr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++;
    if ({req_ready, rsp_valid, rsp_err, apb_sel, apb_enable, apb_write} !== 12'b0) begin
      err_cnt++;
      $display("FAIL reset.ctrl: got rdy=%b rv=%b err=%b sel=%b en=%b wr=%b, exp all 0",
               req_ready, rsp_valid, rsp_err, apb_sel, apb_enable, apb_write);
    end
    vec_cnt++;
    if ({apb_addr, apb_wdata, rsp_rdata} !== 96'b0) begin
      err_cnt++;
      $display("FAIL reset.data: got addr=%h wdata=%h rdata=%h, exp 0", apb_addr, apb_wdata, rsp_rdata);
    end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    req_valid = 4'b0001; req_write = 4'b0000; req_addr[31:0] = 32'h4;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL single_read.accept: got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0; req_addr[31:0] = 32'hDEAD_BEEF;
    #1;
    vec_cnt++;
    if ({apb_sel, apb_enable, apb_write, apb_addr} !== {3'b100, 32'h4}) begin
      err_cnt++; $display("FAIL single_read.setup: got sel=%b en=%b wr=%b addr=%h exp 1 0 0 00000004",
                          apb_sel, apb_enable, apb_write, apb_addr);
    end
    @(negedge clk);
    apb_ready = 1'b1; apb_rdata = 32'hA5;
    #1;
    vec_cnt++;
    if ({apb_sel, apb_enable, apb_addr} !== {2'b11, 32'h4}) begin
      err_cnt++; $display("FAIL single_read.access: got sel=%b en=%b addr=%h exp 1 1 00000004",
                          apb_sel, apb_enable, apb_addr);
    end
    @(negedge clk);
    apb_ready = 1'b0; apb_rdata = '0;
    #1;
    vec_cnt++;
    if ({rsp_valid, rsp_rdata, rsp_err, apb_sel, apb_enable} !== {4'b0001, 32'hA5, 3'b000}) begin
      err_cnt++; $display("FAIL single_read.resp: got rv=%b rdata=%h err=%b sel=%b en=%b exp 0001 000000a5 0 0 0",
                          rsp_valid, rsp_rdata, rsp_err, apb_sel, apb_enable);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({rsp_valid, apb_addr, apb_sel} !== 37'b0) begin
      err_cnt++; $display("FAIL single_read.idle: got rv=%b addr=%h sel=%b exp 0", rsp_valid, apb_addr, apb_sel);
    end
  endtask

  task automatic test_write_wait();
    // ready while IDLE with no request must do nothing
    apb_ready = 1'b1;
    @(negedge clk);
    apb_ready = 1'b0;
    #1;
    vec_cnt++;
    if ({apb_sel, rsp_valid} !== 5'b0) begin
      err_cnt++; $display("FAIL write_wait.idle_ready: got sel=%b rv=%b exp 0", apb_sel, rsp_valid);
    end
    req_valid = 4'b0100; req_write = 4'b0100; req_addr[95:64] = 32'h8; req_wdata[95:64] = 32'h5A;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++; $display("FAIL write_wait.accept: got %b exp 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0; req_write = '0; req_addr[95:64] = '0; req_wdata[95:64] = '0;
    apb_ready = 1'b1;  // ready during SETUP is ignored
    #1;
    vec_cnt++;
    if ({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata} !== {3'b101, 32'h8, 32'h5A}) begin
      err_cnt++; $display("FAIL write_wait.setup: got sel=%b en=%b wr=%b addr=%h wdata=%h",
                          apb_sel, apb_enable, apb_write, apb_addr, apb_wdata);
    end
    @(negedge clk);
    apb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++;
      if ({apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, rsp_valid} !== {3'b111, 32'h8, 32'h5A, 4'b0}) begin
        err_cnt++; $display("FAIL write_wait.access%0d: got sel=%b en=%b wr=%b addr=%h wdata=%h rv=%b",
                            i, apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, rsp_valid);
      end
      @(negedge clk);
    end
    apb_ready = 1'b1; apb_rdata = 32'hFFFF_FFFF;
    #1;
    vec_cnt++;
    if ({apb_enable, apb_addr, rsp_valid} !== {1'b1, 32'h8, 4'b0}) begin
      err_cnt++; $display("FAIL write_wait.last_access: got en=%b addr=%h rv=%b", apb_enable, apb_addr, rsp_valid);
    end
    @(negedge clk);
    apb_ready = 1'b0; apb_rdata = '0;
    #1;
    vec_cnt++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {4'b0100, 32'h0, 1'b0}) begin
      err_cnt++; $display("FAIL write_wait.resp: got rv=%b rdata=%h err=%b exp 0100 00000000 0",
                          rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_slverr();
    // rr_ptr is 3 here; lone requester 1 is reached by wrapping
    req_valid = 4'b0010; req_write = '0; req_addr[63:32] = 32'h10;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL slverr.accept: got %b exp 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    apb_ready = 1'b1; apb_slverr = 1'b1; apb_rdata = 32'h1234;
    @(negedge clk);
    apb_ready = 1'b0; apb_slverr = 1'b0; apb_rdata = '0;
    #1;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {4'b0010, 1'b1, 32'h1234}) begin
      err_cnt++; $display("FAIL slverr.resp: got rv=%b err=%b rdata=%h exp 0010 1 00001234",
                          rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_dropped_valid();
    req_valid = 4'b0001; req_addr[31:0] = 32'h20;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL dropped.accept: got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1000;  // requester 3 raises valid while busy
    @(negedge clk);
    apb_ready = 1'b1;
    @(negedge clk);
    apb_ready = 1'b0; req_valid = '0;  // and drops it before IDLE
    #1;
    vec_cnt++;
    if (rsp_valid !== 4'b0001) begin
      err_cnt++; $display("FAIL dropped.resp: got %b exp 0001", rsp_valid);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0000) begin
      err_cnt++; $display("FAIL dropped.no_accept: got %b exp 0000", req_ready);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({apb_sel, apb_enable} !== 2'b00) begin
      err_cnt++; $display("FAIL dropped.no_xfer: got sel=%b en=%b exp 0 0", apb_sel, apb_enable);
    end
  endtask

  task automatic test_reset_mid_access();
    // rr_ptr is 1; requester 1 granted
    req_valid = 4'b0010; req_addr[63:32] = 32'h30;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL rst_mid.accept: got %b exp 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    vec_cnt++;
    if ({req_ready, rsp_valid, apb_sel, apb_enable, apb_addr} !== 42'b0) begin
      err_cnt++; $display("FAIL rst_mid.outputs: got rdy=%b rv=%b sel=%b en=%b addr=%h exp 0",
                          req_ready, rsp_valid, apb_sel, apb_enable, apb_addr);
    end
    apb_ready = 1'b1;
    @(negedge clk);
    apb_ready = 1'b0;
    #1;
    vec_cnt++;
    if (rsp_valid !== 4'b0) begin
      err_cnt++; $display("FAIL rst_mid.no_rsp: got %b exp 0000", rsp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic got;
    logic [3:0] exp_oh;
    got = 1'b0;
    req_valid = 4'b1111; req_write = '0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (req_ready !== 4'b0) got = 1'b1;
      else @(negedge clk);
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++; $display("FAIL contention.wait: got no accept exp accept within 8 cycles");
    end
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      #1;
      vec_cnt++;
      if (req_ready !== exp_oh) begin
        err_cnt++; $display("FAIL contention.grant%0d: got %b exp %b", k, req_ready, exp_oh);
      end
      @(negedge clk);
      @(negedge clk);
      apb_ready = 1'b1; apb_rdata = 32'h100 + k;
      @(negedge clk);
      apb_ready = 1'b0;
      #1;
      vec_cnt++;
      if ({rsp_valid, rsp_rdata} !== {exp_oh, 32'h100 + k}) begin
        err_cnt++; $display("FAIL contention.rsp%0d: got rv=%b rdata=%h exp %b %h",
                            k, rsp_valid, rsp_rdata, exp_oh, 32'h100 + k);
      end
      @(negedge clk);
    end
    req_valid = '0; apb_rdata = '0;
    @(negedge clk);
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 4'b0001;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++; $display("FAIL timeout.accept: got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      #1;
      vec_cnt++;
      if ({apb_enable, rsp_valid} !== 5'b10000) begin
        err_cnt++; $display("FAIL timeout.access%0d: got en=%b rv=%b exp 1 0000", i, apb_enable, rsp_valid);
      end
      @(negedge clk);
    end
    #1;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable} !== {4'b0001, 1'b1, 32'h0, 2'b00}) begin
      err_cnt++; $display("FAIL timeout.resp: got rv=%b err=%b rdata=%h sel=%b en=%b exp 0001 1 0 0 0",
                          rsp_valid, rsp_err, rsp_rdata, apb_sel, apb_enable);
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if ({apb_sel, rsp_valid} !== 5'b0) begin
      err_cnt++; $display("FAIL timeout.after: got sel=%b rv=%b exp 0", apb_sel, rsp_valid);
    end
  endtask
`endif

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    apb_rdata = '0; apb_ready = 1'b0; apb_slverr = 1'b0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_slverr();
    test_dropped_valid();
    test_reset_mid_access();
    test_contention();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
